// File: rtl/sdram_pkg.sv
// Shared types and default widths for the SDRAM request queue slice.
package sdram_pkg;

    localparam int unsigned ADDR_W_D = 23;
    localparam int unsigned DATA_W_D = 16;

    typedef struct packed {
        logic                we;
        logic [ADDR_W_D-1:0] addr;
        logic [DATA_W_D-1:0] wdata;
    } sdram_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } rq_state_t;

endpackage

// File: rtl/sdram_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; head entry is read combinationally.
module sdram_cmd_fifo
    import sdram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  sdram_cmd_t                   i_cmd,
    input  logic                         i_pop,
    output sdram_cmd_t                   o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    sdram_cmd_t       r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Storage array carries no reset; only entries below r_count are ever read as valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_cmd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/sdram_req_queue.sv
// Queues read/write commands and issues them one at a time to the single-word SDRAM controller,
// with a watchdog that aborts a request the controller never completes.
module sdram_req_queue
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_D,
    parameter int unsigned DATA_W  = DATA_W_D,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_done,
    output logic              err,
    input  logic              err_clr,
    output logic              idle,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    output logic              ctl_wrreq,
    output logic              ctl_rereq,
    input  logic [DATA_W-1:0] ctl_rdata,
    input  logic              ctl_rwdone,
    input  logic              ctl_busy,
    input  logic              ctl_wait
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned WDW = $clog2(TIMEOUT);

    rq_state_t         r_state, w_state_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_wrreq, w_wrreq_nxt;
    logic              r_rereq, w_rereq_nxt;
    logic              r_rd_valid, w_rd_valid_nxt;
    logic              r_wr_done, w_wr_done_nxt;
    logic [DATA_W-1:0] r_rd_data, w_rd_data_nxt;
    logic              r_err, w_err_nxt;
    logic [WDW-1:0]    r_wd_cnt, w_wd_cnt_nxt;

    logic              w_push, w_pop, w_full, w_empty;
    logic [CW-1:0]     w_count;
    sdram_cmd_t        w_push_cmd, w_head;
    logic              w_req, w_wd_expired;
    logic              w_unused;

    // ctl_wait is observed for debug visibility only.
    assign w_unused = ctl_wait;

    assign w_push       = cmd_valid && !w_full;
    assign w_push_cmd   = '{we: cmd_we, addr: ADDR_W_D'(cmd_addr), wdata: DATA_W_D'(cmd_wdata)};
    assign w_req        = r_wrreq || r_rereq;
    assign w_wd_expired = (r_wd_cnt == WDW'(TIMEOUT - 1));

    sdram_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_cmd   (w_push_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wrreq    <= 1'b0;
            r_rereq    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_wr_done  <= 1'b0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
            r_wd_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_wrreq    <= w_wrreq_nxt;
            r_rereq    <= w_rereq_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_wr_done  <= w_wr_done_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_err      <= w_err_nxt;
            r_wd_cnt   <= w_wd_cnt_nxt;
        end
    end

    // Completion paths assert the strobe on entry to DONE so it is high for the DONE cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_we_nxt       = r_we;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_wrreq_nxt    = r_wrreq;
        w_rereq_nxt    = r_rereq;
        w_rd_valid_nxt = 1'b0;
        w_wr_done_nxt  = 1'b0;
        w_rd_data_nxt  = r_rd_data;
        w_err_nxt      = err_clr ? 1'b0 : r_err;
        w_wd_cnt_nxt   = r_wd_cnt;
        w_pop          = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_we_nxt     = w_head.we;
                    w_addr_nxt   = ADDR_W'(w_head.addr);
                    w_wdata_nxt  = DATA_W'(w_head.wdata);
                    w_wd_cnt_nxt = '0;
                    w_state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                if (w_req) begin
                    if (ctl_rwdone) begin
                        w_wrreq_nxt    = 1'b0;
                        w_rereq_nxt    = 1'b0;
                        w_rd_valid_nxt = !r_we;
                        w_wr_done_nxt  = r_we;
                        if (!r_we) begin
                            w_rd_data_nxt = ctl_rdata;
                        end
                        w_state_nxt = DONE;
                    end else if (w_wd_expired) begin
                        w_wrreq_nxt = 1'b0;
                        w_rereq_nxt = 1'b0;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_wd_cnt_nxt = r_wd_cnt + WDW'(1);
                        if (ctl_busy) begin
                            w_wrreq_nxt = 1'b0;
                            w_rereq_nxt = 1'b0;
                            w_state_nxt = WAIT;
                        end
                    end
                end else if (!ctl_busy) begin
                    w_wrreq_nxt  = r_we;
                    w_rereq_nxt  = !r_we;
                    w_wd_cnt_nxt = '0;
                end
            end
            WAIT: begin
                if (ctl_rwdone) begin
                    w_rd_valid_nxt = !r_we;
                    w_wr_done_nxt  = r_we;
                    if (!r_we) begin
                        w_rd_data_nxt = ctl_rdata;
                    end
                    w_state_nxt = DONE;
                end else if (w_wd_expired) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_wd_cnt_nxt = r_wd_cnt + WDW'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_ready = !w_full;
    assign idle      = (w_count == '0) && (r_state == IDLE);
    assign ctl_addr  = r_addr;
    assign ctl_wdata = r_wdata;
    assign ctl_wrreq = r_wrreq;
    assign ctl_rereq = r_rereq;
    assign rd_valid  = r_rd_valid;
    assign wr_done   = r_wr_done;
    assign rd_data   = r_rd_data;
    assign err       = r_err;

endmodule

// File: doc/sdram_req_queue.md
Name: sdram_req_queue

Overview:
- Upstream front-end for the single-word SDRAM controller (sdram_con2).
- Accepts read/write commands from a valid/ready bus into a small FIFO.
- Issues them to the controller one at a time, using the controller's wrreq/rereq, rw_busy and rwdone handshake.
- Returns read data on a one-cycle valid strobe. A watchdog flags a controller that never completes.

Parameters:
- ADDR_W, 23, word address width (matches controller address input)
- DATA_W, 16, data width (matches controller data bus)
- DEPTH, 4, command FIFO entries; power of two, >= 2
- TIMEOUT, 1024, max cycles from request assertion to rwdone before abort

Ports:
- clk  in  1  single clock, shared with controller
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue can accept (= not full)
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  word address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rd_valid  out  1  one-cycle strobe, rd_data valid
- rd_data  out  DATA_W  read result
- wr_done  out  1  one-cycle strobe, write completed
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err
- idle  out  1  FIFO empty and FSM in IDLE
- ctl_addr  out  ADDR_W  to controller address
- ctl_wdata  out  DATA_W  to controller write data
- ctl_wrreq  out  1  controller write request
- ctl_rereq  out  1  controller read request
- ctl_rdata  in  DATA_W  controller read data, valid in rwdone cycle
- ctl_rwdone  in  1  controller completion pulse
- ctl_busy  in  1  controller busy
- ctl_wait  in  1  controller wait (monitored only; no behavioural effect)

Behaviour:
- Reset (async, immediate):
  - FIFO emptied.
  - FSM to IDLE.
  - ctl_wrreq = ctl_rereq = 0.
  - ctl_addr = ctl_wdata = 0, rd_data = 0.
  - rd_valid = wr_done = err = 0.
  - cmd_ready = 1, idle = 1.
- Reset mid-operation discards all queued and in-flight commands; no strobe is produced for them.
- Push happens when cmd_valid && cmd_ready. A push while full cannot occur because cmd_ready = 0.
- Simultaneous push and pop is legal at any occupancy except full. Push while full is excluded; pop while empty cannot occur.
- Occupancy counter is log2(DEPTH)+1 bits. Pointers are log2(DEPTH) bits and wrap naturally.
- FSM states are IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If the FIFO is non-empty, pop the head entry.
  - Register we/addr/wdata into ctl_addr/ctl_wdata and a latched we bit.
  - Go to ISSUE.
  - A command pushed into an empty FIFO in cycle N is popped in N+1; ISSUE is entered in N+2.
- ISSUE:
  - If ctl_busy = 0, assert ctl_wrreq (we = 1) or ctl_rereq (we = 0), registered.
  - Hold the request until ctl_busy is sampled high, then deassert it the next cycle and go to WAIT.
  - If ctl_rwdone arrives while the request is asserted, treat it as completion and go directly to DONE.
- WAIT: on ctl_rwdone, capture ctl_rdata (reads only) and go to DONE.
- DONE:
  - Pulse rd_valid (read) or wr_done (write) for exactly one cycle.
  - rd_data is updated on reads and holds its value otherwise.
  - Return to IDLE. Back-to-back commands therefore cost at least 4 cycles plus controller latency.
- ctl_addr/ctl_wdata are stable from ISSUE entry until DONE exit.
- Watchdog:
  - A counter starts at the first cycle the request is asserted and counts through ISSUE and WAIT.
  - At TIMEOUT-1 without rwdone: set err, drop both requests, discard the entry (no strobe), return to IDLE.
  - Counter width is clog2(TIMEOUT).
- err is sticky. err_clr clears it. If err_clr and a new timeout occur in the same cycle, set wins.
- ctl_rwdone seen in IDLE or DONE is ignored (spurious).
- ctl_wrreq and ctl_rereq are never both 1.

Decomposition:
- Package sdram_pkg:
  - typedef sdram_cmd_t struct {we, addr[ADDR_W], wdata[DATA_W]}
  - enum rq_state_t {IDLE, ISSUE, WAIT, DONE}
  - default width constants ADDR_W_D = 23, DATA_W_D = 16
- Sub-module sdram_cmd_fifo:
  - Parameterised synchronous FIFO of sdram_cmd_t.
  - push/pop/full/empty/count interface, async active-high reset.
- Top holds the FSM, the watchdog and the output registers.

Test Plan:
- Single write: push we = 1, addr = 0x000005, wdata = 0xA5A5; controller model (busy 2 cycles after req, rwdone 3 cycles later) -> ctl_wrreq high until busy seen; ctl_addr = 0x000005 and ctl_wdata = 0xA5A5 stable; wr_done one cycle; idle returns to 1.
- Write then read: write 0x1234 to addr 7, read addr 7 (model returns stored data) -> rd_valid one cycle with rd_data = 0x1234; ordering preserved.
- Fill: push 16 commands addr 0..15 with controller stalled (busy held high) -> cmd_ready = 0 after DEPTH+1 accepts (4 queued + 1 in flight); release -> 16 strobes in address order, none lost or duplicated.
- Busy at entry: ctl_busy = 1 when ISSUE entered -> no request asserted until busy = 0, then exactly one request.
- Timeout: TIMEOUT = 16, model never asserts rwdone -> err = 1 at cycle 16 after request; requests drop; next queued command proceeds; err_clr -> err = 0.
- Async reset mid-WAIT with 3 queued -> outputs at reset values within the same cycle; no rd_valid/wr_done after release; cmd_ready = 1, idle = 1.
